timing_error_ctrl: RTL and testbench

- Consumes the one-cycle `transition` flag produced by the transition detector (a late data transition, i.e. a timing error) and runs the pipeline recovery sequence: stall the pipeline, pulse a shadow-register restore, then release.
- Also keeps a saturating total error count and a per-epoch error-rate monitor.
- The rate monitor raises `throttle` to the clock/voltage control logic when errors become too frequent.
- Sits directly downstream of the detector and upstream of pipeline-control and DVFS logic.

---
 rtl/timing_error_ctrl.sv | 122 ++++++++++++
 tb/tb_timing_error_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/timing_error_ctrl.sv
// rtl/timing_error_ctrl.sv - timing-error recovery sequencer with error counter and rate monitor
module timing_error_ctrl #(
    parameter int STALL_CYCLES = 2,
    parameter int EPOCH_LEN    = 16,
    parameter int THRESH       = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             transition,
    input  logic             clr_count,
    output logic             stall,
    output logic             restore,
    output logic             busy,
    output logic [CNT_W-1:0] error_count,
    output logic             throttle
);

    localparam int EP_W = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STALL,
        S_RESTORE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        scnt_q, scnt_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [EP_W-1:0]   epoch_q, epoch_d;
    logic [7:0]        ep_err_q, ep_err_d;
    logic              thr_d;
    logic [8:0]        ep_sum;
    logic [8:0]        ep_total;

    // Recovery sequencer: IDLE -> STALL (fixed length) -> RESTORE -> IDLE or STALL again
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        case (state_q)
            S_IDLE: begin
                if (transition) begin
                    state_d = S_STALL;
                    scnt_d  = 8'(STALL_CYCLES - 1);
                end
            end
            S_STALL: begin
                // Errors seen here are counted but do not lengthen the stall
                if (scnt_q == 8'd0) begin
                    state_d = S_RESTORE;
                end else begin
                    scnt_d = scnt_q - 8'd1;
                end
            end
            S_RESTORE: begin
                if (transition) begin
                    state_d = S_STALL;
                    scnt_d  = 8'(STALL_CYCLES - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Saturating total error count with synchronous clear
    always_comb begin
        cnt_d = error_count;
        if (clr_count) begin
            cnt_d = CNT_W'(transition);
        end else if (transition && (error_count != {CNT_W{1'b1}})) begin
            cnt_d = error_count + CNT_W'(1);
        end
    end

    // Epoch rate monitor; throttle only moves at the last edge of an epoch
    always_comb begin
        ep_sum   = {1'b0, ep_err_q} + {8'd0, transition};
        ep_total = (ep_sum >= 9'(THRESH)) ? 9'(THRESH) : ep_sum;
        thr_d    = throttle;
        epoch_d  = epoch_q + EP_W'(1);
        ep_err_d = ep_total[7:0];
        if (epoch_q == EP_W'(EPOCH_LEN - 1)) begin
            epoch_d  = '0;
            ep_err_d = 8'd0;
            if (ep_total >= 9'(THRESH)) begin
                thr_d = 1'b1;
            end else if (ep_total == 9'd0) begin
                thr_d = 1'b0;
            end
        end
    end

    // State and registered outputs; outputs are decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            scnt_q      <= 8'd0;
            stall       <= 1'b0;
            restore     <= 1'b0;
            busy        <= 1'b0;
            error_count <= '0;
            epoch_q     <= '0;
            ep_err_q    <= 8'd0;
            throttle    <= 1'b0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            stall       <= (state_d != S_IDLE);
            restore     <= (state_d == S_RESTORE);
            busy        <= (state_d != S_IDLE);
            error_count <= cnt_d;
            epoch_q     <= epoch_d;
            ep_err_q    <= ep_err_d;
            throttle    <= thr_d;
        end
    end

endmodule

// File: tb/tb_timing_error_ctrl.sv
// tb/tb_timing_error_ctrl.sv - randomized and directed bench for timing_error_ctrl against a behavioural model
module tb_timing_error_ctrl;

    localparam int STALL_CYCLES = 2;
    localparam int EPOCH_LEN    = 16;
    localparam int THRESH       = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       transition = 1'b0;
    logic       clr_count = 1'b0;
    logic       stall, restore, busy, throttle;
    logic [7:0] error_count;
    logic       stall_s, restore_s, busy_s, throttle_s;
    logic [1:0] error_count_s;

    int n_checks = 0;
    int n_errors = 0;

    // model state: remaining stalled cycles, counts, epoch position
    int rec_left = 0;
    int cnt8 = 0;
    int cnt2 = 0;
    int ep_pos = 0;
    int ep_errs = 0;
    int thr = 0;

    always #5 clk = ~clk;

    timing_error_ctrl #(
        .STALL_CYCLES(STALL_CYCLES), .EPOCH_LEN(EPOCH_LEN), .THRESH(THRESH), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .transition(transition), .clr_count(clr_count),
        .stall(stall), .restore(restore), .busy(busy),
        .error_count(error_count), .throttle(throttle)
    );

    timing_error_ctrl #(
        .STALL_CYCLES(STALL_CYCLES), .EPOCH_LEN(EPOCH_LEN), .THRESH(THRESH), .CNT_W(2)
    ) dut_s (
        .clk(clk), .reset(reset), .transition(transition), .clr_count(clr_count),
        .stall(stall_s), .restore(restore_s), .busy(busy_s),
        .error_count(error_count_s), .throttle(throttle_s)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge of the reference behaviour
    task automatic model_step(input bit t, input bit c, input bit r);
        int e;
        if (r) begin
            rec_left = 0; cnt8 = 0; cnt2 = 0; ep_pos = 0; ep_errs = 0; thr = 0;
        end else begin
            // a new window starts from idle or from the restore cycle
            if ((rec_left <= 1) && t) rec_left = STALL_CYCLES + 1;
            else if (rec_left > 0) rec_left = rec_left - 1;
            if (c) begin
                cnt8 = t; cnt2 = t;
            end else if (t) begin
                cnt8 = (cnt8 + 1 > 255) ? 255 : cnt8 + 1;
                cnt2 = (cnt2 + 1 > 3) ? 3 : cnt2 + 1;
            end
            if (ep_pos == EPOCH_LEN - 1) begin
                e = ep_errs + t;
                if (e >= THRESH) thr = 1;
                else if (e == 0) thr = 0;
                ep_errs = 0;
                ep_pos = 0;
            end else begin
                ep_errs = ep_errs + t;
                ep_pos = ep_pos + 1;
            end
        end
    endtask

    task automatic cyc(input bit t, input bit c, input bit r);
        transition = t;
        clr_count  = c;
        reset      = r;
        @(posedge clk);
        model_step(t, c, r);
        #1;
        check("stall", stall, (rec_left > 0) ? 1 : 0);
        check("restore", restore, (rec_left == 1) ? 1 : 0);
        check("busy", busy, (rec_left > 0) ? 1 : 0);
        check("error_count", error_count, cnt8);
        check("throttle", throttle, thr);
        check("error_count_w2", error_count_s, cnt2);
        check("stall_w2", stall_s, (rec_left > 0) ? 1 : 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 1);
        cyc(0, 0, 1);
    endtask

    initial begin
        // reset state
        do_reset();
        check("reset_stall", stall, 0);
        check("reset_count", error_count, 0);
        check("reset_throttle", throttle, 0);

        // single error: three stalled cycles, restore on the last
        idle(2);
        cyc(1, 0, 0);
        check("t1_stall_on", stall, 1);
        check("t1_restore_off", restore, 0);
        idle(1);
        check("t1_restore_off2", restore, 0);
        idle(1);
        check("t1_restore_on", restore, 1);
        idle(1);
        check("t1_stall_off", stall, 0);
        check("t1_busy_off", busy, 0);
        check("t1_count", error_count, 1);
        idle(4);

        // second error during STALL does not extend recovery
        do_reset();
        idle(2);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        idle(1);
        check("t2_restore", restore, 1);
        idle(1);
        check("t2_stall_off", stall, 0);
        check("t2_count", error_count, 2);
        idle(4);

        // error in RESTORE re-enters STALL
        do_reset();
        idle(2);
        cyc(1, 0, 0);
        idle(2);
        check("t3_restore1", restore, 1);
        cyc(1, 0, 0);
        check("t3_restall", stall, 1);
        check("t3_restore_off", restore, 0);
        idle(2);
        check("t3_restore2", restore, 1);
        idle(1);
        check("t3_stall_off", stall, 0);
        check("t3_count", error_count, 2);

        // throttle hysteresis over aligned epochs
        do_reset();
        for (int i = 0; i < EPOCH_LEN; i++) cyc((i == 1 || i == 5 || i == 9), 0, 0);
        check("t4_thr_set", throttle, 1);
        for (int i = 0; i < EPOCH_LEN; i++) cyc((i == EPOCH_LEN - 1), 0, 0);
        check("t4_thr_hold", throttle, 1);
        for (int i = 0; i < EPOCH_LEN; i++) cyc(0, 0, 0);
        check("t4_thr_clear", throttle, 0);
        for (int i = 0; i < EPOCH_LEN; i++) cyc((i >= EPOCH_LEN - 3), 0, 0);
        check("t4_thr_last_edge", throttle, 1);

        // saturation and clear in the narrow counter
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1, 0, 0);
        check("t5_sat", error_count_s, 3);
        idle(4);
        check("t5_sat_hold", error_count_s, 3);
        cyc(0, 1, 0);
        check("t5_clr", error_count_s, 0);
        cyc(1, 1, 0);
        check("t5_clr_inc", error_count_s, 1);
        idle(6);

        // reset in the middle of STALL, with an ignored transition
        do_reset();
        for (int i = 0; i < EPOCH_LEN; i++) cyc((i < 3), 0, 0);
        idle(2);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 1);
        check("t6_stall", stall, 0);
        check("t6_restore", restore, 0);
        check("t6_busy", busy, 0);
        check("t6_throttle", throttle, 0);
        check("t6_count", error_count, 0);
        cyc(1, 0, 0);
        check("t6_recover", stall, 1);
        idle(5);

        // randomized traffic, bursty errors, occasional clear and reset
        for (int i = 0; i < 3000; i++) begin
            bit t, c, r;
            t = ((i / 64) % 2 == 0) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 299) == 0);
            cyc(t, c, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
